// File: rtl/dpbram_burst_reader.sv
// Burst read engine for a 1-cycle-latency block RAM port, streaming words out on valid/ready.
// Optional abort input is enabled by defining DPBRAM_RD_ABORT_EN.
module dpbram_burst_reader #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned LEN_W  = 11
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [LEN_W-1:0]  len,
`ifdef DPBRAM_RD_ABORT_EN
   input  logic              abort,
`endif
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_en,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t             state_q;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   issued_q;
   logic               inflight_q;
   logic [1:0]         count_q;
   logic [1:0]         count_next;
   logic [DATA_W-1:0]  buf1_q;
   logic [1:0]         occ;
   logic               pop;
   logic               abort_w;

`ifdef DPBRAM_RD_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   // out_data is the skid FIFO head and buf1_q the second entry; a read in flight still counts
   // against the two slots because its data lands in the FIFO unconditionally next cycle.
   assign pop    = out_valid & out_ready;
   assign occ    = count_q + {1'b0, inflight_q};
   assign ram_we = 1'b0;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      ram_en = 1'b0;
      if (state_q == RUN && issued_q != len_q)
         ram_en = (occ < 2'd2) || (occ == 2'd2 && pop);
   end

   always_comb begin
      count_next = count_q;
      unique case ({inflight_q, pop})
         2'b10:   count_next = count_q + 2'd1;
         2'b01:   count_next = count_q - 2'd1;
         default: count_next = count_q;
      endcase
   end

   // NOTE: the two skid entries are reset too, so out_data reads 0 straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         len_q      <= '0;
         issued_q   <= '0;
         inflight_q <= 1'b0;
         count_q    <= '0;
         buf1_q     <= '0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         ram_addr   <= '0;
      end else begin
         done       <= 1'b0;
         inflight_q <= ram_en;
         count_q    <= count_next;
         out_valid  <= (count_next != 2'd0);

         if (ram_en) begin
            ram_addr <= ram_addr + 1'b1;
            issued_q <= issued_q + 1'b1;
         end

         unique case ({inflight_q, pop})
            2'b10: begin
               if (count_q == 2'd0) out_data <= ram_rdata;
               else                 buf1_q   <= ram_rdata;
            end
            2'b01: out_data <= buf1_q;
            2'b11: begin
               if (count_q == 2'd1) begin
                  out_data <= ram_rdata;
               end else begin
                  out_data <= buf1_q;
                  buf1_q   <= ram_rdata;
               end
            end
            default: ;
         endcase

         unique case (state_q)
            IDLE: begin
               if (start && !abort_w) begin
                  len_q    <= len;
                  ram_addr <= start_addr;
                  issued_q <= '0;
                  busy     <= 1'b1;
                  state_q  <= (len == '0) ? FIN : RUN;
               end
            end
            RUN: begin
               if (issued_q == len_q && !inflight_q && count_q == 2'd0)
                  state_q <= FIN;
            end
            FIN: begin
               state_q <= IDLE;
               busy    <= 1'b0;
               done    <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase

         // Abort drops everything buffered or in flight and returns silently to IDLE.
         if (abort_w && state_q != IDLE) begin
            state_q    <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            out_valid  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dpbram_burst_reader.sv
// Randomized bench for dpbram_burst_reader: a RAM model plus a per-burst expected-word queue
// built from the address arithmetic, checked by a negedge monitor.
module tb_dpbram_burst_reader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [9:0]  start_addr;
   logic [10:0] len;
   logic        abort;
   logic        busy, done, ram_en, ram_we, out_valid, out_ready;
   logic [9:0]  ram_addr;
   logic [31:0] ram_rdata, out_data;

   logic [31:0] mem [1024];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   dpbram_burst_reader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .start_addr (start_addr),
      .len        (len),
`ifdef DPBRAM_RD_ABORT_EN
      .abort      (abort),
`endif
      .busy       (busy),
      .done       (done),
      .ram_addr   (ram_addr),
      .ram_en     (ram_en),
      .ram_we     (ram_we),
      .ram_rdata  (ram_rdata),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

   always @(posedge clk) if (ram_en) ram_rdata <= mem[ram_addr];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Reference model: expected word queue and issue/pop bookkeeping for the current burst.
   int          cyc = 0;
   bit          active = 0;
   logic [9:0]  m_addr;
   int          m_len = 0, m_issued = 0, m_popped = 0, exp_done = 0;
   logic [31:0] exp_q [$];
   bit          prev_stall = 0, prev_abort = 0;
   logic [31:0] prev_data;
   logic [9:0]  ea;
   bit          pop;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         active = 0; exp_q.delete(); m_len = 0; m_issued = 0; m_popped = 0;
         prev_stall = 0; prev_abort = 0;
      end else begin
         pop = out_valid && out_ready;
         if (prev_stall && !prev_abort) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, prev_data);
         end
         if (ram_en) begin
            check("en_busy", busy, 1);
            check("we_zero", ram_we, 0);
            check("en_budget", m_issued < m_len, 1);
            check("en_room", (m_issued - m_popped < 2) || pop, 1);
            ea = m_addr + 10'(m_issued);
            check("rd_addr", ram_addr, ea);
            m_issued++;
         end
         if (pop) begin
            if (exp_q.size() == 0) check("pop_extra", 1, 0);
            else check("data", out_data, exp_q.pop_front());
            m_popped++;
            if (m_popped == m_len) exp_done = cyc + 3;
         end
         if (done) begin
            if (!active) check("done_spurious", 1, 0);
            else begin
               check("done_cycle", cyc, exp_done);
               check("done_left", exp_q.size(), 0);
               check("done_busy", busy, 0);
               active = 0;
            end
         end
         if (abort && busy) begin
            active = 0; exp_q.delete(); m_len = 0; m_issued = 0; m_popped = 0;
         end
         if (start && !busy && !abort) begin
            active = 1; m_addr = start_addr; m_len = int'(len); m_issued = 0; m_popped = 0;
            exp_q.delete();
            for (int i = 0; i < m_len; i++) exp_q.push_back(mem[10'(int'(start_addr) + i)]);
            if (m_len == 0) exp_done = cyc + 2;
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_abort = abort && busy;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_burst(input logic [9:0] a, input int l, input int mode);
      bit seen = 0;
      int budget = 8 * l + 50;
      start = 1; start_addr = a; len = 11'(l);
      out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      step();
      start = 0;
      for (int n = 0; n < budget && !seen; n++) begin
         @(negedge clk);
         if (done) seen = 1;
         step();
         out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      check("done_seen", seen, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int pops;
      rst_n = 0; start = 0; start_addr = '0; len = '0; abort = 0; out_ready = 0;
      for (int k = 0; k < 1024; k++) mem[k] = 32'(k);
      #12;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_en", ram_en, 0);
      check("rst_valid", out_valid, 0);
      check("rst_addr", ram_addr, 0);
      check("rst_data", out_data, 0);
      #11 rst_n = 1;
      step();

      // Directed: len 4 from 0x010 with ready held high, cycle-exact.
      start = 1; start_addr = 10'h010; len = 11'd4; out_ready = 1;
      step();
      start = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         check("t1_valid", out_valid, (c >= 3 && c <= 6));
         if (c >= 3 && c <= 6) check("t1_data", out_data, 32'h10 + 32'(c - 3));
         check("t1_busy", busy, (c >= 1 && c <= 8));
         check("t1_done", done, (c == 9));
         step();
      end

      run_burst(10'h3FE, 4, 0);

      for (int k = 0; k < 1024; k++) mem[k] = $urandom;

      run_burst(10'($urandom), 16, 1);

      // len 0: no reads, done two cycles after start, a start during FIN is ignored.
      start = 1; start_addr = 10'h123; len = '0; out_ready = 1;
      step();
      start = 0;
      check("l0_busy", busy, 1);
      check("l0_done_early", done, 0);
      check("l0_valid", out_valid, 0);
      start = 1; len = 11'd5;
      step();
      start = 0;
      check("l0_done", done, 1);
      check("l0_busy_low", busy, 0);
      check("l0_en", ram_en, 0);
      step();
      check("l0_ignored", busy, 0);
      check("l0_done_once", done, 0);

      for (int i = 0; i < 12; i++)
         run_burst(10'($urandom), $urandom_range(1, 40), $urandom_range(0, 1));

      run_burst(10'h300, 1100, 0);

      // Reset after the fifth word of ten.
      start = 1; start_addr = 10'($urandom); len = 11'd10; out_ready = 1;
      step();
      start = 0;
      pops = 0;
      for (int n = 0; n < 100 && pops < 5; n++) begin
         @(negedge clk);
         if (out_valid && out_ready) pops++;
         if (pops < 5) step();
      end
      check("rst_reach", pops, 5);
      #2 rst_n = 0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_en", ram_en, 0);
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_data", out_data, 0);
      check("mid_rst_addr", ram_addr, 0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1;
      step();
      run_burst(10'h000, 2, 0);

`ifdef DPBRAM_RD_ABORT_EN
      start = 1; start_addr = 10'($urandom); len = 11'd8; out_ready = 1;
      step();
      start = 0;
      pops = 0;
      for (int n = 0; n < 100 && pops < 3; n++) begin
         @(negedge clk);
         if (out_valid && out_ready) pops++;
         if (pops < 3) step();
      end
      check("abort_reach", pops, 3);
      step();
      out_ready = 0; abort = 1;
      step();
      abort = 0;
      check("abort_valid", out_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      run_burst(10'($urandom), 5, 1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
